// File: rtl/pc_sequencer.sv
// Fetch-stage program counter. It advances by 4, takes redirects, exception entry and eret,
// holds one redirect that arrives during a stall, and flags misaligned or out-of-window PCs.
module pc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h3000,
  parameter logic [WIDTH-1:0] LOW      = 32'h3000,
  parameter logic [WIDTH-1:0] HIGH     = 32'h4ffc,
  parameter logic [WIDTH-1:0] HANDLER  = 32'h4180
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_redirect_valid,
  input  logic [WIDTH-1:0] i_redirect_target,
  input  logic             i_exc_enter,
  input  logic             i_eret,
  input  logic [WIDTH-1:0] i_epc,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_pc_fault,
  output logic             o_pending
);

  typedef enum logic {StRun, StHeld} state_e;

  localparam logic [WIDTH-1:0] PcStep = WIDTH'(4);

  state_e           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pend_target;

  // Branch order encodes the next-PC priority; a stall only blocks the lower branches.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_pend_target <= '0;
      r_state       <= StRun;
    end else if (i_exc_enter) begin
      r_pc    <= HANDLER;
      r_state <= StRun;
    end else if (i_eret) begin
      r_pc    <= i_epc;
      r_state <= StRun;
    end else if (i_stall) begin
      if (i_redirect_valid) begin
        r_pend_target <= i_redirect_target;
        r_state       <= StHeld;
      end
    end else if (i_redirect_valid) begin
      r_pc    <= i_redirect_target;
      r_state <= StRun;
    end else if (r_state == StHeld) begin
      r_pc    <= r_pend_target;
      r_state <= StRun;
    end else begin
      r_pc <= r_pc + PcStep;
    end
  end

  logic w_misaligned;
  logic w_out_of_range;

  assign w_misaligned   = (r_pc[1:0] != 2'b00);
  assign w_out_of_range = (r_pc < LOW) || (r_pc > HIGH);

  assign o_pc       = r_pc;
  assign o_pc_fault = w_misaligned || w_out_of_range;
  assign o_pending  = (r_state == StHeld);

endmodule
